// File: rtl/arq_pkg.sv
// arq_pkg: shared state encoding, feedback polarity and default limits for the ARQ controllers
package arq_pkg;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] FB    = 3'd3;
  localparam logic [2:0] FAIL  = 3'd4;
  localparam logic FB_ACK  = 1'b0;
  localparam logic FB_NACK = 1'b1;
  localparam int TIMEOUT_CYC_DEF = 16384;
  localparam int MAX_RETRY_DEF   = 3;
endpackage

// File: rtl/arq_rx_ctrl_if.sv
// arq_rx_ctrl_if: demapper, client FIFO and feedback signals of the receive-side ARQ controller
interface arq_rx_ctrl_if #(parameter int CNT_W = 13, parameter int RETRY_W = 2);
  logic               i_frame_fas;
  logic               i_pyld_data_valid;
  logic               i_crc_err;
  logic               i_crc_err_valid;
  logic               i_arq_en;
  logic               i_arq_en_valid;
  logic               i_fb_ready;
  logic               o_fifo_commit;
  logic               o_fifo_discard;
  logic [CNT_W-1:0]   o_fifo_byte_cnt;
  logic               o_fb_valid;
  logic               o_fb_nack;
  logic [RETRY_W-1:0] o_retry_cnt;
  logic               o_timeout;
  logic               o_link_fail;
  modport slave (
    input  i_frame_fas, i_pyld_data_valid, i_crc_err, i_crc_err_valid, i_arq_en, i_arq_en_valid, i_fb_ready,
    output o_fifo_commit, o_fifo_discard, o_fifo_byte_cnt, o_fb_valid, o_fb_nack, o_retry_cnt, o_timeout, o_link_fail
  );
  modport master (
    output i_frame_fas, i_pyld_data_valid, i_crc_err, i_crc_err_valid, i_arq_en, i_arq_en_valid, i_fb_ready,
    input  o_fifo_commit, o_fifo_discard, o_fifo_byte_cnt, o_fb_valid, o_fb_nack, o_retry_cnt, o_timeout, o_link_fail
  );
endinterface

// File: rtl/arq_timeout_cnt.sv
// arq_timeout_cnt: clear/enable cycle counter flagging terminal count TC-1
module arq_timeout_cnt #(
  parameter int W  = 15,
  parameter int TC = 16384
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [W-1:0] cnt;
  // clear wins over enable so a new frame always starts from zero
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) cnt <= '0;
    else cnt <= i_clr ? '0 : i_en ? cnt + 1'b1 : cnt;
  assign o_tc = cnt == W'(TC - 1);
endmodule

// File: rtl/arq_rx_ctrl.sv
// arq_rx_ctrl: sequences per-frame CRC outcome into FIFO commit/discard and ACK/NACK feedback
module arq_rx_ctrl
  import arq_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TO_W        = 15,
  parameter int MAX_RETRY   = MAX_RETRY_DEF,
  parameter int RETRY_W     = 2,
  parameter int CNT_W       = 13
) (
  input logic i_clk,
  input logic i_rst,
  arq_rx_ctrl_if.slave bus
);
  logic [2:0]         state, nxt, exit_st;
  logic               err, to_flag, nack, pend, arq_en, tc, start;
  logic [CNT_W-1:0]   bytes;
  logic [RETRY_W-1:0] retry;
  assign exit_st = (pend || bus.i_frame_fas) ? RECV : IDLE;
  assign start   = nxt == RECV && state != RECV;
  arq_timeout_cnt #(.W(TO_W), .TC(TIMEOUT_CYC)) u_to (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(start),
    .i_en (state == RECV),
    .o_tc (tc)
  );
  // next state: a verdict, timeout or premature FAS all close the frame into CHECK
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = bus.i_frame_fas ? RECV : IDLE;
      RECV:    nxt = (bus.i_crc_err_valid || tc || bus.i_frame_fas) ? CHECK : RECV;
      CHECK:   nxt = !arq_en ? exit_st : (err && retry == RETRY_W'(MAX_RETRY - 1)) ? FAIL : FB;
      FB:      nxt = bus.i_fb_ready ? exit_st : FB;
      FAIL:    nxt = FAIL;
      default: nxt = IDLE;
    endcase
  end
  // frame bookkeeping: verdict latch, retry count, pending FAS and byte count
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      state   <= IDLE;
      err     <= 1'b0;
      to_flag <= 1'b0;
      nack    <= FB_ACK;
      pend    <= 1'b0;
      arq_en  <= 1'b0;
      retry   <= '0;
      bytes   <= '0;
    end else begin
      state <= nxt;
      if (state != FAIL && bus.i_arq_en_valid) arq_en <= bus.i_arq_en;
      if (state == RECV && nxt == CHECK) begin
        err     <= bus.i_crc_err_valid ? bus.i_crc_err : 1'b1;
        to_flag <= !bus.i_crc_err_valid && tc;
      end
      if (state == CHECK) begin
        nack  <= err ? FB_NACK : FB_ACK;
        retry <= !err ? '0 : arq_en ? retry + 1'b1 : retry;
      end
      pend  <= start ? 1'b0 : (state inside {RECV, CHECK, FB} && bus.i_frame_fas) ? 1'b1 : pend;
      bytes <= start ? '0 : (state == RECV && bus.i_pyld_data_valid && !(&bytes)) ? bytes + 1'b1 : bytes;
    end
  assign bus.o_fifo_commit   = state == CHECK && !err;
  assign bus.o_fifo_discard  = state == CHECK && err;
  assign bus.o_timeout       = state == CHECK && to_flag;
  assign bus.o_fifo_byte_cnt = state == FAIL ? '0 : bytes;
  assign bus.o_fb_valid      = state == FB;
  assign bus.o_fb_nack       = state == FB && nack;
  assign bus.o_retry_cnt     = state == FAIL ? '0 : retry;
  assign bus.o_link_fail     = state == FAIL;
endmodule

// File: tb/tb_arq_rx_ctrl.sv
// tb_arq_rx_ctrl: randomized frame scenarios checked against a per-frame ARQ outcome model
module tb_arq_rx_ctrl;
  localparam int MAXR = 3;
  localparam int TO_SMALL = 64;
  logic clk, rst_n;
  int errors, checks, m_retry;
  arq_rx_ctrl_if #(.CNT_W(13), .RETRY_W(2)) bus ();
  arq_rx_ctrl_if #(.CNT_W(13), .RETRY_W(2)) bus_to ();
  arq_rx_ctrl dut (.i_clk(clk), .i_rst(rst_n), .bus(bus));
  arq_rx_ctrl #(.TIMEOUT_CYC(TO_SMALL), .TO_W(7)) dut_to (.i_clk(clk), .i_rst(rst_n), .bus(bus_to));
  assign bus_to.i_frame_fas       = bus.i_frame_fas;
  assign bus_to.i_pyld_data_valid = bus.i_pyld_data_valid;
  assign bus_to.i_crc_err         = bus.i_crc_err;
  assign bus_to.i_crc_err_valid   = bus.i_crc_err_valid;
  assign bus_to.i_arq_en          = bus.i_arq_en;
  assign bus_to.i_arq_en_valid    = bus.i_arq_en_valid;
  assign bus_to.i_fb_ready        = bus.i_fb_ready;
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not end, got timeout exp finish");
    $fatal(1);
  end
  function automatic logic [20:0] outs();
    return {bus.o_fifo_commit, bus.o_fifo_discard, bus.o_fifo_byte_cnt, bus.o_fb_valid,
            bus.o_fb_nack, bus.o_retry_cnt, bus.o_timeout, bus.o_link_fail};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_in();
    bus.i_frame_fas = 0; bus.i_pyld_data_valid = 0; bus.i_crc_err = 0; bus.i_crc_err_valid = 0;
    bus.i_arq_en = 0; bus.i_arq_en_valid = 0; bus.i_fb_ready = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    clr_in();
    repeat (2) cyc();
    rst_n = 1;
    cyc();
    m_retry = 0;
  endtask
  // one frame: FAS, nb bytes with random gaps, verdict (with ARQ enable), then feedback handshake
  task automatic run_frame(input int nb, input bit e, input bit arq, input int dly, input bit fas_fb, input bit no_fas);
    logic [12:0] xb;
    bit fail;
    if (!no_fas) begin
      bus.i_frame_fas = 1; cyc(); bus.i_frame_fas = 0;
    end
    for (int i = 0; i < nb; i++) begin
      while ($urandom_range(0, 3) == 0) cyc();
      bus.i_pyld_data_valid = 1; cyc(); bus.i_pyld_data_valid = 0;
    end
    xb = nb > 8191 ? 13'h1fff : 13'(nb);
    bus.i_crc_err = e; bus.i_crc_err_valid = 1; bus.i_arq_en = arq; bus.i_arq_en_valid = 1;
    checks++;
    if ({bus.o_fifo_commit, bus.o_fifo_discard} !== 2'b00) begin
      errors++; $display("FAIL early_pulse: got %b exp 00", {bus.o_fifo_commit, bus.o_fifo_discard});
    end
    cyc();
    bus.i_crc_err_valid = 0; bus.i_arq_en_valid = 0;
    checks++;
    if ({bus.o_fifo_commit, bus.o_fifo_discard, bus.o_timeout} !== {~e, e, 1'b0}) begin
      errors++; $display("FAIL verdict: got c/d/t=%b exp %b", {bus.o_fifo_commit, bus.o_fifo_discard, bus.o_timeout}, {~e, e, 1'b0});
    end
    checks++;
    if (bus.o_fifo_byte_cnt !== xb) begin
      errors++; $display("FAIL byte_cnt: got %0d exp %0d", bus.o_fifo_byte_cnt, xb);
    end
    if (arq) m_retry = e ? m_retry + 1 : 0;
    else if (!e) m_retry = 0;
    fail = arq && e && m_retry == MAXR;
    cyc();
    checks++;
    if ({bus.o_fifo_commit, bus.o_fifo_discard} !== 2'b00) begin
      errors++; $display("FAIL pulse_width: got %b exp 00", {bus.o_fifo_commit, bus.o_fifo_discard});
    end
    if (fail) begin
      checks++;
      if ({bus.o_link_fail, bus.o_fb_valid, bus.o_retry_cnt} !== 4'b1000) begin
        errors++; $display("FAIL link_fail: got lf/fbv/retry=%b exp 1000", {bus.o_link_fail, bus.o_fb_valid, bus.o_retry_cnt});
      end
      return;
    end
    checks++;
    if ({bus.o_fb_valid, bus.o_fb_nack, bus.o_retry_cnt} !== {arq, arq & e, 2'(m_retry)}) begin
      errors++; $display("FAIL feedback: got v/n/retry=%b exp %b", {bus.o_fb_valid, bus.o_fb_nack, bus.o_retry_cnt}, {arq, arq & e, 2'(m_retry)});
    end
    if (!arq) return;
    for (int k = 0; k < dly; k++) begin
      if (fas_fb && k == dly / 2) bus.i_frame_fas = 1;
      cyc();
      bus.i_frame_fas = 0;
      checks++;
      if ({bus.o_fb_valid, bus.o_fb_nack} !== {1'b1, e}) begin
        errors++; $display("FAIL fb_hold: got v/n=%b exp %b", {bus.o_fb_valid, bus.o_fb_nack}, {1'b1, e});
      end
    end
    bus.i_fb_ready = 1; cyc(); bus.i_fb_ready = 0;
    checks++;
    if (bus.o_fb_valid !== 1'b0) begin
      errors++; $display("FAIL fb_drop: got %b exp 0", bus.o_fb_valid);
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (outs() !== 21'd0) begin
      errors++; $display("FAIL reset_idle: got %h exp 0", outs());
    end
    bus.i_frame_fas = 1; cyc(); bus.i_frame_fas = 0;
    repeat (3) begin bus.i_pyld_data_valid = 1; cyc(); end
    bus.i_pyld_data_valid = 0;
    bus.i_crc_err = 1; bus.i_crc_err_valid = 1; bus.i_arq_en = 1; bus.i_arq_en_valid = 1;
    cyc();
    clr_in();
    rst_n = 0;
    #1;
    checks++;
    if (outs() !== 21'd0) begin
      errors++; $display("FAIL reset_async: got %h exp 0", outs());
    end
    cyc(); rst_n = 1; cyc(); cyc();
    checks++;
    if (outs() !== 21'd0) begin
      errors++; $display("FAIL reset_after: got %h exp 0", outs());
    end
    m_retry = 0;
  endtask
  task automatic test_commit();
    do_reset();
    run_frame(100, 0, 1, 3, 0, 0);
  endtask
  task automatic test_retry();
    do_reset();
    run_frame(20, 1, 1, $urandom_range(0, 4), 0, 0);
    run_frame(20, 1, 1, $urandom_range(0, 4), 0, 0);
    run_frame(20, 0, 1, $urandom_range(0, 4), 0, 0);
  endtask
  task automatic test_fail();
    do_reset();
    repeat (3) run_frame($urandom_range(1, 15), 1, 1, 1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      bus.i_frame_fas = 1'($urandom); bus.i_pyld_data_valid = 1'($urandom);
      bus.i_crc_err = 1'($urandom); bus.i_crc_err_valid = 1'($urandom);
      bus.i_arq_en = 1'($urandom); bus.i_arq_en_valid = 1'($urandom); bus.i_fb_ready = 1'($urandom);
      cyc();
      checks++;
      if (outs() !== 21'd1) begin
        errors++; $display("FAIL fail_sticky: got %h exp 1", outs());
      end
    end
    clr_in();
  endtask
  task automatic test_timeout();
    int k;
    do_reset();
    bus.i_arq_en = 1; bus.i_arq_en_valid = 1; cyc(); bus.i_arq_en_valid = 0;
    bus.i_frame_fas = 1; cyc(); bus.i_frame_fas = 0;
    k = 1;
    while (bus_to.o_timeout !== 1'b1 && k < 200) begin cyc(); k++; end
    checks++;
    if (k != TO_SMALL + 1) begin
      errors++; $display("FAIL timeout_cycle: got %0d exp %0d", k, TO_SMALL + 1);
    end
    checks++;
    if ({bus_to.o_timeout, bus_to.o_fifo_discard, bus_to.o_fifo_commit} !== 3'b110) begin
      errors++; $display("FAIL timeout_discard: got t/d/c=%b exp 110", {bus_to.o_timeout, bus_to.o_fifo_discard, bus_to.o_fifo_commit});
    end
    cyc();
    checks++;
    if ({bus_to.o_timeout, bus_to.o_fb_valid, bus_to.o_fb_nack, bus_to.o_retry_cnt} !== 5'b01101) begin
      errors++; $display("FAIL timeout_nack: got t/v/n/retry=%b exp 01101", {bus_to.o_timeout, bus_to.o_fb_valid, bus_to.o_fb_nack, bus_to.o_retry_cnt});
    end
    bus.i_fb_ready = 1; cyc(); bus.i_fb_ready = 0;
  endtask
  task automatic test_arq_off();
    do_reset();
    run_frame(10, 1, 0, 0, 0, 0);
    run_frame(7, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({bus.o_fb_valid, bus.o_retry_cnt} !== 3'b000) begin
        errors++; $display("FAIL arq_off: got v/retry=%b exp 000", {bus.o_fb_valid, bus.o_retry_cnt});
      end
    end
  endtask
  task automatic test_fb_fas();
    do_reset();
    run_frame(12, 0, 1, 10, 1, 0);
    run_frame(5, 1, 1, 2, 0, 1);
    bus.i_frame_fas = 1; cyc(); bus.i_frame_fas = 0;
    repeat (3) begin bus.i_pyld_data_valid = 1; cyc(); end
    bus.i_pyld_data_valid = 0;
    bus.i_crc_err = 0; bus.i_crc_err_valid = 1; bus.i_arq_en = 1; bus.i_arq_en_valid = 1;
    cyc(); clr_in(); cyc();
    checks++;
    if (bus.o_fb_valid !== 1'b1) begin
      errors++; $display("FAIL fb_before_rst: got %b exp 1", bus.o_fb_valid);
    end
    rst_n = 0;
    #1;
    checks++;
    if (bus.o_fb_valid !== 1'b0) begin
      errors++; $display("FAIL fb_rst_async: got %b exp 0", bus.o_fb_valid);
    end
    cyc(); rst_n = 1; cyc();
    m_retry = 0;
    checks++;
    if (outs() !== 21'd0) begin
      errors++; $display("FAIL fb_rst_idle: got %h exp 0", outs());
    end
    run_frame(4, 0, 1, 1, 0, 0);
  endtask
  task automatic test_saturate();
    do_reset();
    run_frame(8195, 0, 0, 0, 0, 0);
  endtask
  task automatic test_random();
    bit pend, e, arq, ff;
    int dly;
    do_reset();
    pend = 0;
    for (int f = 0; f < 25; f++) begin
      e = 1'($urandom);
      arq = $urandom_range(0, 3) != 0;
      dly = $urandom_range(0, 4);
      ff = arq && dly > 0 && $urandom_range(0, 1) == 1;
      run_frame($urandom_range(0, 30), e, arq, dly, ff, pend);
      if (m_retry == MAXR) begin
        do_reset();
        pend = 0;
      end else pend = ff;
    end
  endtask
  initial begin
    errors = 0;
    checks = 0;
    m_retry = 0;
    rst_n = 0;
    clr_in();
    test_reset();
    test_commit();
    test_retry();
    test_fail();
    test_timeout();
    test_arq_off();
    test_fb_fas();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arq_rx_ctrl.md
Name: arq_rx_ctrl

Overview:
Receiver-side ARQ frame controller that sequences the demapper's per-frame outcome. It tracks each frame from FAS to CRC verdict and tells the client FIFO to commit or discard the frame's payload bytes. When ARQ is enabled by the peer, it issues ACK/NACK feedback requests to the rec_tran transmitter. It counts consecutive NACKs and latches a link-fail condition after MAX_RETRY failures.

Parameters:
TIMEOUT_CYC, 16384, cycles allowed in RECV before CRC verdict; expiry is treated as a CRC error.
TO_W, 15, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.
MAX_RETRY, 3, consecutive NACKs that trigger FAIL.
RETRY_W, 2, retry counter width; must satisfy 2^RETRY_W > MAX_RETRY.
CNT_W, 13, payload byte counter width.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-low
i_frame_fas  in  1  frame-start strobe from serial receiver
i_pyld_data_valid  in  1  demapper payload byte written to FIFO
i_crc_err  in  1  CRC verdict, 1 = error
i_crc_err_valid  in  1  qualifies i_crc_err, 1-cycle pulse
i_arq_en  in  1  peer ARQ-enable bit
i_arq_en_valid  in  1  qualifies i_arq_en
o_fifo_commit  out  1  1-cycle pulse: keep current frame's bytes
o_fifo_discard  out  1  1-cycle pulse: drop current frame's bytes
o_fifo_byte_cnt  out  CNT_W  bytes in frame; valid with commit/discard
o_fb_valid  out  1  feedback request to rec_tran
o_fb_nack  out  1  0 = ACK, 1 = NACK; stable while o_fb_valid
i_fb_ready  in  1  rec_tran accepts feedback
o_retry_cnt  out  RETRY_W  consecutive NACK count
o_timeout  out  1  1-cycle pulse on verdict timeout
o_link_fail  out  1  sticky fail flag

Behaviour:
- Reset (i_rst = 0, async): state IDLE; all outputs 0; r_arq_en = 0; retry, byte and timeout counters = 0; pending-FAS flag = 0.
- r_arq_en updates on every i_arq_en_valid in any state except FAIL. If i_arq_en_valid coincides with the CRC verdict, the new value governs that CHECK.
- IDLE: on i_frame_fas, go to RECV. Byte counter and timeout counter are cleared.
- RECV:
  - Byte counter increments on i_pyld_data_valid and saturates at all-ones.
  - Timeout counter increments every cycle.
  - i_crc_err_valid: latch i_crc_err and go to CHECK.
  - Timeout counter reaching TIMEOUT_CYC-1 without a verdict: latch err = 1, pulse o_timeout, go to CHECK.
  - i_frame_fas (premature next frame): latch err = 1, set pending-FAS, go to CHECK. Verdict takes priority over a simultaneous FAS; the FAS still sets pending-FAS.
- CHECK: lasts exactly one cycle. Verdict sampled at cycle N gives CHECK at N+1, with the commit or discard pulse in that cycle.
  - err = 0: o_fifo_commit pulses; retry_cnt cleared.
  - err = 1: o_fifo_discard pulses.
  - r_arq_en = 0: no feedback and no retry counting. Go to RECV if pending-FAS, else IDLE.
  - r_arq_en = 1, err = 0: go to FB with nack = 0.
  - r_arq_en = 1, err = 1, retry_cnt == MAX_RETRY-1: retry_cnt increments, go to FAIL.
  - r_arq_en = 1, err = 1, otherwise: retry_cnt increments, go to FB with nack = 1.
- FB:
  - o_fb_valid = 1 from N+2; o_fb_nack is held until the cycle where i_fb_ready = 1.
  - On the accepting cycle, o_fb_valid drops next cycle. Go to RECV if pending-FAS (counters cleared, flag cleared), else IDLE.
  - i_frame_fas during FB sets pending-FAS. A data byte during FB is not counted.
- FAIL: o_link_fail = 1. All other outputs 0 and all inputs ignored. Only reset exits.
- Byte count is held from CHECK until the next frame start.

Decomposition:
- Shared package arq_pkg holds:
  - state encoding localparams: IDLE, RECV, CHECK, FB, FAIL;
  - FB_ACK / FB_NACK constants;
  - default TIMEOUT_CYC and MAX_RETRY.
- One sub-module, arq_timeout_cnt, is natural: a clear/enable counter with terminal-count output, reused by the transmit-side ARQ.
- FSM, byte counter and retry logic stay in arq_rx_ctrl.

Test Plan:
- ARQ on, FAS, 100 byte-valids, crc_err = 0 at cycle N: o_fifo_commit at N+1 with byte_cnt = 100; o_fb_valid with nack = 0 at N+2; ready after 3 cycles, then back to IDLE.
- ARQ on, 2 error frames then 1 good frame: discard, discard, commit; o_retry_cnt goes 1, 2, 0; nack = 1, 1, 0.
- ARQ on, 3 consecutive error frames: third CHECK pulses discard, then o_link_fail = 1 and stays high; further FAS and CRC inputs produce no outputs.
- FAS with no verdict for TIMEOUT_CYC cycles (set 64 in bench): o_timeout and o_fifo_discard at the same cycle; NACK issued.
- ARQ off with crc_err = 1: discard only; o_fb_valid never asserts; retry_cnt stays 0.
- FAS arriving while FB waits for i_fb_ready (held low 10 cycles): after accept, goes directly to RECV and the next verdict is processed. Drop i_rst mid-FB: o_fb_valid = 0 immediately and the FSM returns to IDLE.
